// File: rtl/alu_issue_stage.sv
// ID->EX issue register for the 64-bit ALU.
// Accepts one decoded instruction per cycle over valid/ready, resolves EX/MEM and
// MEM/WB forwarding, selects the ALU operands, decodes the ALU select and holds the
// result as a registered bundle that stays bit-stable while downstream stalls.
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   flush                       drop the held bundle and the incoming instruction
//   in_valid / in_ready         upstream handshake (in_ready is combinational)
//   in_pc .. in_rd_wen          decoded instruction fields from ID
//   fwd_exm_* / fwd_wb_*        forwarding sources from EX/MEM and MEM/WB
//   out_valid / out_ready       downstream handshake
//   out_op1 .. out_illegal      registered operand bundle for the ALU and EX/MEM
module alu_issue_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RA_W-1:0]  in_rs1_addr,
    input  logic [RA_W-1:0]  in_rs2_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [1:0]       in_aluop,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7_5,
    input  logic             in_is_rtype,
    input  logic             in_src1_pc,
    input  logic             in_src2_imm,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_rd_wen,
    input  logic             fwd_exm_en,
    input  logic [RA_W-1:0]  fwd_exm_rd,
    input  logic [XLEN-1:0]  fwd_exm_data,
    input  logic             fwd_wb_en,
    input  logic [RA_W-1:0]  fwd_wb_rd,
    input  logic [XLEN-1:0]  fwd_wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [SEL_W-1:0] out_alu_sel,
    output logic [XLEN-1:0]  out_store_data,
    output logic [XLEN-1:0]  out_pc,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_rd_wen,
    output logic             out_illegal
);

    localparam logic [SEL_W-1:0] SEL_AND  = SEL_W'(4'b0000);
    localparam logic [SEL_W-1:0] SEL_OR   = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0] SEL_ADD  = SEL_W'(4'b0010);
    localparam logic [SEL_W-1:0] SEL_SUB  = SEL_W'(4'b0110);
    localparam logic [SEL_W-1:0] SEL_PASS = SEL_W'(4'b1111);

    typedef struct packed {
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [SEL_W-1:0] alu_sel;
        logic [XLEN-1:0]  store_data;
        logic [XLEN-1:0]  pc;
        logic [RA_W-1:0]  rd;
        logic             rd_wen;
        logic             illegal;
    } bundle_t;

    bundle_t         bundle_q;
    bundle_t         bundle_d;
    logic            valid_q;
    logic            accept;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [SEL_W-1:0] sel_d;
    logic            illegal_d;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Forwarding: EX/MEM beats MEM/WB; x0 always reads the regfile value.
    always_comb begin
        rs1_fwd = in_rs1_data;
        if (fwd_exm_en && (fwd_exm_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            rs1_fwd = fwd_exm_data;
        end else if (fwd_wb_en && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            rs1_fwd = fwd_wb_data;
        end
    end

    always_comb begin
        rs2_fwd = in_rs2_data;
        if (fwd_exm_en && (fwd_exm_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            rs2_fwd = fwd_exm_data;
        end else if (fwd_wb_en && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            rs2_fwd = fwd_wb_data;
        end
    end

    // ALU select decode; unsupported arith funct3 falls back to pass and flags illegal.
    always_comb begin
        sel_d     = SEL_PASS;
        illegal_d = 1'b0;
        unique case (in_aluop)
            2'b00: sel_d = SEL_ADD;
            2'b01: sel_d = SEL_SUB;
            2'b11: sel_d = SEL_PASS;
            2'b10: begin
                unique case (in_funct3)
                    3'b000:  sel_d = (in_is_rtype && in_funct7_5) ? SEL_SUB : SEL_ADD;
                    3'b111:  sel_d = SEL_AND;
                    3'b110:  sel_d = SEL_OR;
                    default: begin
                        sel_d     = SEL_PASS;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: sel_d = SEL_PASS;
        endcase
    end

    // Next bundle assembled from the incoming instruction.
    always_comb begin
        bundle_d            = '0;
        bundle_d.op1        = in_src1_pc  ? in_pc  : rs1_fwd;
        bundle_d.op2        = in_src2_imm ? in_imm : rs2_fwd;
        bundle_d.alu_sel    = sel_d;
        bundle_d.store_data = rs2_fwd;
        bundle_d.pc         = in_pc;
        bundle_d.rd         = in_rd;
        bundle_d.rd_wen     = in_rd_wen;
        bundle_d.illegal    = illegal_d;
    end

    // Bundle register: flush wins, then accept, then plain consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign out_op1        = bundle_q.op1;
    assign out_op2        = bundle_q.op2;
    assign out_alu_sel    = bundle_q.alu_sel;
    assign out_store_data = bundle_q.store_data;
    assign out_pc         = bundle_q.pc;
    assign out_rd         = bundle_q.rd;
    assign out_rd_wen     = bundle_q.rd_wen;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic [1:0]  in_aluop;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_is_rtype;
    logic        in_src1_pc;
    logic        in_src2_imm;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        fwd_exm_en;
    logic [4:0]  fwd_exm_rd;
    logic [63:0] fwd_exm_data;
    logic        fwd_wb_en;
    logic [4:0]  fwd_wb_rd;
    logic [63:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op1;
    logic [63:0] out_op2;
    logic [3:0]  out_alu_sel;
    logic [63:0] out_store_data;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_aluop       (in_aluop),
        .in_funct3      (in_funct3),
        .in_funct7_5    (in_funct7_5),
        .in_is_rtype    (in_is_rtype),
        .in_src1_pc     (in_src1_pc),
        .in_src2_imm    (in_src2_imm),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .fwd_exm_en     (fwd_exm_en),
        .fwd_exm_rd     (fwd_exm_rd),
        .fwd_exm_data   (fwd_exm_data),
        .fwd_wb_en      (fwd_wb_en),
        .fwd_wb_rd      (fwd_wb_rd),
        .fwd_wb_data    (fwd_wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_op1        (out_op1),
        .out_op2        (out_op2),
        .out_alu_sel    (out_alu_sel),
        .out_store_data (out_store_data),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rd_wen     (out_rd_wen),
        .out_illegal    (out_illegal)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain R-type ADD from rs1/rs2, no forwarding, valid asserted.
    task automatic set_plain(input logic [63:0] d1, input logic [63:0] d2);
        in_valid    = 1'b1;
        in_pc       = 64'h1000;
        in_rs1_addr = 5'd1;
        in_rs2_addr = 5'd2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = 64'h0;
        in_aluop    = 2'b10;
        in_funct3   = 3'b000;
        in_funct7_5 = 1'b0;
        in_is_rtype = 1'b1;
        in_src1_pc  = 1'b0;
        in_src2_imm = 1'b0;
        in_rd       = 5'd9;
        in_rd_wen   = 1'b1;
        fwd_exm_en  = 1'b0;
        fwd_exm_rd  = 5'd0;
        fwd_exm_data = 64'h0;
        fwd_wb_en   = 1'b0;
        fwd_wb_rd   = 5'd0;
        fwd_wb_data = 64'h0;
    endtask

    // Decode table: aluop, funct3, is_rtype, funct7_5 -> expected select and illegal.
    typedef struct {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic       rt;
        logic       f7;
        logic [3:0] sel;
        logic       ill;
    } dec_vec_t;

    dec_vec_t dec_tab[8] = '{
        '{2'b00, 3'b101, 1'b1, 1'b1, 4'b0010, 1'b0},
        '{2'b01, 3'b000, 1'b0, 1'b0, 4'b0110, 1'b0},
        '{2'b11, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b0},
        '{2'b10, 3'b000, 1'b0, 1'b1, 4'b0010, 1'b0},
        '{2'b10, 3'b000, 1'b1, 1'b0, 4'b0010, 1'b0},
        '{2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0},
        '{2'b10, 3'b110, 1'b1, 1'b0, 4'b0001, 1'b0},
        '{2'b10, 3'b100, 1'b1, 1'b0, 4'b1111, 1'b1}
    };

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_plain(64'd77, 64'd88);

        // Reset held two cycles with a valid instruction pending.
        tick();
        tick();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_op1", out_op1, 64'd0);
        check_eq("rst_sel", 64'(out_alu_sel), 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd1);

        // R-type SUB x3 - x4.
        rst_n = 1'b1;
        set_plain(64'd10, 64'd3);
        in_rs1_addr = 5'd3;
        in_rs2_addr = 5'd4;
        in_funct7_5 = 1'b1;
        in_pc       = 64'h200;
        in_rd       = 5'd7;
        tick();
        check_eq("sub_valid", 64'(out_valid), 64'd1);
        check_eq("sub_op1", out_op1, 64'd10);
        check_eq("sub_op2", out_op2, 64'd3);
        check_eq("sub_sel", 64'(out_alu_sel), 64'h6);
        check_eq("sub_store", out_store_data, 64'd3);
        check_eq("sub_pc", out_pc, 64'h200);
        check_eq("sub_rd", 64'(out_rd), 64'd7);
        check_eq("sub_wen", 64'(out_rd_wen), 64'd1);
        check_eq("sub_ill", 64'(out_illegal), 64'd0);

        // Forwarding: EX/MEM beats MEM/WB on both sources.
        set_plain(64'h11, 64'h22);
        in_rs1_addr  = 5'd5;
        in_rs2_addr  = 5'd5;
        in_aluop     = 2'b00;
        in_src2_imm  = 1'b1;
        in_imm       = 64'h20;
        fwd_exm_en   = 1'b1;
        fwd_exm_rd   = 5'd5;
        fwd_exm_data = 64'hAA;
        fwd_wb_en    = 1'b1;
        fwd_wb_rd    = 5'd5;
        fwd_wb_data  = 64'hBB;
        tick();
        check_eq("fwd_exm_op1", out_op1, 64'hAA);
        check_eq("fwd_imm_op2", out_op2, 64'h20);
        check_eq("fwd_exm_store", out_store_data, 64'hAA);
        check_eq("fwd_add_sel", 64'(out_alu_sel), 64'h2);

        // MEM/WB alone.
        fwd_exm_en = 1'b0;
        tick();
        check_eq("fwd_wb_op1", out_op1, 64'hBB);
        check_eq("fwd_wb_store", out_store_data, 64'hBB);

        // EX/MEM enabled but to a different register: MEM/WB still used.
        fwd_exm_en = 1'b1;
        fwd_exm_rd = 5'd6;
        tick();
        check_eq("fwd_exm_miss", out_op1, 64'hBB);

        // x0 never forwarded.
        in_rs1_addr = 5'd0;
        in_rs2_addr = 5'd0;
        in_rs1_data = 64'h55;
        in_rs2_data = 64'h66;
        fwd_exm_rd  = 5'd0;
        fwd_wb_rd   = 5'd0;
        tick();
        check_eq("x0_op1", out_op1, 64'h55);
        check_eq("x0_store", out_store_data, 64'h66);

        // op1 from pc.
        set_plain(64'h1, 64'h2);
        in_src1_pc = 1'b1;
        in_pc      = 64'hDEAD_0000_1234;
        tick();
        check_eq("src1_pc", out_op1, 64'hDEAD_0000_1234);

        // Stall: bundle A held while B waits, then B and C back-to-back.
        set_plain(64'd1, 64'd0);
        tick();
        check_eq("stall_a", out_op1, 64'd1);
        out_ready = 1'b0;
        set_plain(64'd2, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_ready", 64'(in_ready), 64'd0);
            tick();
            check_eq("stall_hold", out_op1, 64'd1);
            check_eq("stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("release_ready", 64'(in_ready), 64'd1);
        tick();
        check_eq("release_b", out_op1, 64'd2);
        set_plain(64'd3, 64'd0);
        tick();
        check_eq("release_c", out_op1, 64'd3);
        check_eq("release_c_vld", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", 64'(out_valid), 64'd0);

        // Flush while stalled with a new instruction present.
        set_plain(64'd4, 64'd0);
        tick();
        check_eq("pre_flush", out_op1, 64'd4);
        set_plain(64'd5, 64'd0);
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("flush_dropped", 64'(out_valid), 64'd0);

        // Illegal arith funct3.
        set_plain(64'd8, 64'd9);
        in_funct3 = 3'b001;
        tick();
        check_eq("ill_sel", 64'(out_alu_sel), 64'hF);
        check_eq("ill_flag", 64'(out_illegal), 64'd1);

        // Mem-address add with negative immediate.
        set_plain(64'd8, 64'd9);
        in_aluop    = 2'b00;
        in_src2_imm = 1'b1;
        in_imm      = -64'sd8;
        tick();
        check_eq("imm_sel", 64'(out_alu_sel), 64'h2);
        check_eq("imm_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("imm_ill", 64'(out_illegal), 64'd0);
        check_eq("imm_store", out_store_data, 64'd9);

        // Decode table sweep.
        for (int i = 0; i < 8; i++) begin
            set_plain(64'd1, 64'd2);
            in_aluop    = dec_tab[i].aluop;
            in_funct3   = dec_tab[i].f3;
            in_is_rtype = dec_tab[i].rt;
            in_funct7_5 = dec_tab[i].f7;
            tick();
            check_eq($sformatf("dec%0d_sel", i), 64'(out_alu_sel), 64'(dec_tab[i].sel));
            check_eq($sformatf("dec%0d_ill", i), 64'(out_illegal), 64'(dec_tab[i].ill));
        end

        // Reset applied mid-stall discards the held bundle.
        set_plain(64'd42, 64'd0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check_eq("pre_rst_hold", out_op1, 64'd42);
        rst_n = 1'b0;
        tick();
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_op1", out_op1, 64'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
